fft_input_buffer: RTL and testbench

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_input_buffer.sv | 114 +++++++++++
 tb/tb_fft_input_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_buffer.sv
// Frame buffer for a 16-point radix-2 FFT: collects 16 real samples and emits 8 butterfly pairs (x[k], x[k+8]).
// Define FFT_BUF_PINGPONG_EN for two alternating banks (no input stall); default is one bank with an 8-cycle stall per frame.
module fft_input_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [15:0] din,
  output logic        din_ready,
  output logic        pair_valid,
  output logic [63:0] i0,
  output logic [63:0] i1,
  output logic [2:0]  pair_idx,
  output logic        pair_last
);

  typedef enum logic {
    BANK_FILL  = 1'b0,
    BANK_DRAIN = 1'b1
  } bank_state_t;

  bank_state_t bank_st   [2];
  bank_state_t bank_st_d [2];
  logic        wr_sel, wr_sel_d;
  logic        rd_sel, rd_sel_d;
  logic [3:0]  wr_ptr, wr_ptr_d;
  logic [2:0]  rd_ptr, rd_ptr_d;
  logic        din_ready_d;
  logic        xfer;
  logic        drain_active;
  logic [15:0] mem [2][16];

  function automatic logic [63:0] fmt_sample(input logic [15:0] s);
    fmt_sample = {{8{s[15]}}, s, 8'h00, 32'h0000_0000};
  endfunction

  // Banks complete and drain in the same alternating order, so rd_sel simply follows wr_sel one frame behind.
  always_comb begin
    bank_st_d    = bank_st;
    wr_sel_d     = wr_sel;
    rd_sel_d     = rd_sel;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    xfer         = din_valid & din_ready;
    drain_active = (bank_st[rd_sel] == BANK_DRAIN);

    if (xfer) begin
      wr_ptr_d = wr_ptr + 4'd1;
      if (wr_ptr == 4'd15) begin
        bank_st_d[wr_sel] = BANK_DRAIN;
`ifdef FFT_BUF_PINGPONG_EN
        wr_sel_d = ~wr_sel;
`endif
      end
    end

    if (drain_active) begin
      rd_ptr_d = rd_ptr + 3'd1;
      if (rd_ptr == 3'd7) begin
        bank_st_d[rd_sel] = BANK_FILL;
`ifdef FFT_BUF_PINGPONG_EN
        rd_sel_d = ~rd_sel;
`endif
      end
    end

    // Registered next-state view: din_ready mirrors "write bank is in FILL" without touching din_valid.
    din_ready_d = (bank_st_d[wr_sel_d] == BANK_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st   <= '{BANK_FILL, BANK_FILL};
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      din_ready <= 1'b0;
    end else begin
      bank_st   <= bank_st_d;
      wr_sel    <= wr_sel_d;
      rd_sel    <= rd_sel_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      din_ready <= din_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_sel][wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_valid <= 1'b0;
      pair_idx   <= '0;
      pair_last  <= 1'b0;
      i0         <= '0;
      i1         <= '0;
    end else if (drain_active) begin
      pair_valid <= 1'b1;
      pair_idx   <= rd_ptr;
      pair_last  <= (rd_ptr == 3'd7);
      i0         <= fmt_sample(mem[rd_sel][{1'b0, rd_ptr}]);
      i1         <= fmt_sample(mem[rd_sel][{1'b1, rd_ptr}]);
    end else begin
      pair_valid <= 1'b0;
      pair_idx   <= '0;
      pair_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed self-checking bench for fft_input_buffer; follows FFT_BUF_PINGPONG_EN when defined.
module tb_fft_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        din_ready;
  logic        pair_valid;
  logic [63:0] i0;
  logic [63:0] i1;
  logic [2:0]  pair_idx;
  logic        pair_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_edge = 0;

  logic [15:0] stim [64];
  logic [63:0] q_i0 [$];
  logic [63:0] q_i1 [$];
  logic [2:0]  q_idx [$];
  logic        q_last [$];
  int          q_cyc [$];

  fft_input_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .pair_valid (pair_valid),
    .i0         (i0),
    .i1         (i1),
    .pair_idx   (pair_idx),
    .pair_last  (pair_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pair_valid) begin
      q_i0.push_back(i0);
      q_i1.push_back(i1);
      q_idx.push_back(pair_idx);
      q_last.push_back(pair_last);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [63:0] fmt(input logic [15:0] s);
    return {{8{s[15]}}, s, 8'h00, 32'h0000_0000};
  endfunction

  task automatic send(input int n, input bit gaps, output int stalls);
    int i = 0;
    int guard = 0;
    stalls = 0;
    while (i < n && guard < 4000) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        din_valid = 1'b0;
      end else begin
        din_valid = 1'b1;
        din = stim[i];
      end
      @(negedge clk);
      if (!din_ready) stalls++;
      if (din_valid && din_ready) begin
        i++;
        acc_edge = cyc + 1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    din_valid = 1'b0;
    n_tests++;
    if (i != n) begin
      n_fail++;
      $display("FAIL send_accepted: got %0d samples, expected %0d", i, n);
    end
  endtask

  task automatic wait_pairs(input int want);
    int g = 0;
    while (q_i0.size() < want && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  // Checks nf frames of 8 pairs starting at queue index base against stim[16*f ...].
  task automatic check_frames(input string name, input int base, input int nf);
    n_tests++;
    if (q_i0.size() - base != 8 * nf) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pairs, expected %0d", name, q_i0.size() - base, 8 * nf);
    end else begin
      for (int f = 0; f < nf; f++) begin
        for (int k = 0; k < 8; k++) begin
          n_tests++;
          if (q_idx[base + 8*f + k] !== 3'(k) || q_last[base + 8*f + k] !== (k == 7)) begin
            n_fail++;
            $display("FAIL %s_idx f%0d k%0d: got idx %0d last %0b, expected idx %0d last %0b",
                     name, f, k, q_idx[base + 8*f + k], q_last[base + 8*f + k], k, (k == 7));
          end
          n_tests++;
          if (q_i0[base + 8*f + k] !== fmt(stim[16*f + k]) || q_i1[base + 8*f + k] !== fmt(stim[16*f + k + 8])) begin
            n_fail++;
            $display("FAIL %s_data f%0d k%0d: got %h/%h, expected %h/%h", name, f, k,
                     q_i0[base + 8*f + k], q_i1[base + 8*f + k], fmt(stim[16*f + k]), fmt(stim[16*f + k + 8]));
          end
          if (k > 0) begin
            n_tests++;
            if (q_cyc[base + 8*f + k] != q_cyc[base + 8*f] + k) begin
              n_fail++;
              $display("FAIL %s_gapless f%0d k%0d: got cycle %0d, expected %0d", name, f, k,
                       q_cyc[base + 8*f + k], q_cyc[base + 8*f] + k);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (din_ready !== 1'b0 || pair_valid !== 1'b0 || pair_last !== 1'b0 || pair_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy %b pv %b pl %b idx %0d, expected 0 0 0 0", din_ready, pair_valid, pair_last, pair_idx);
    end
    n_tests++;
    if (i0 !== 64'd0 || i1 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h, expected 0/0", i0, i1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_early: got %b, expected 0", din_ready);
    end
    @(negedge clk);
    n_tests++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b, expected 1", din_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int base;
    int st;
    base = q_i0.size();
    for (int i = 0; i < 16; i++) stim[i] = 16'(i);
    send(16, 1'b0, st);
    wait_pairs(base + 8);
    check_frames("basic", base, 1);
    if (q_i0.size() - base == 8) begin
      n_tests++;
      if (q_cyc[base] != acc_edge + 1) begin
        n_fail++;
        $display("FAIL basic_latency: got cycle %0d, expected %0d", q_cyc[base], acc_edge + 1);
      end
      n_tests++;
      if (q_i0[base + 1] !== 64'h0000_0100_0000_0000) begin
        n_fail++;
        $display("FAIL basic_i0_k1: got %h, expected 0000010000000000", q_i0[base + 1]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (pair_valid !== 1'b0 || pair_idx !== 3'd0 || pair_last !== 1'b0 || i0 !== 64'h0000_0700_0000_0000) begin
      n_fail++;
      $display("FAIL basic_idle: got pv %b idx %0d pl %b i0 %h, expected 0 0 0 0000070000000000",
               pair_valid, pair_idx, pair_last, i0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_negative;
    int base;
    int st;
    base = q_i0.size();
    for (int i = 0; i < 16; i++) stim[i] = 16'(i);
    stim[0] = 16'h8000;
    stim[8] = 16'h7FFF;
    send(16, 1'b0, st);
    wait_pairs(base + 8);
    n_tests++;
    if (q_i0.size() <= base) begin
      n_fail++;
      $display("FAIL neg_present: got %0d pairs, expected 8", q_i0.size() - base);
    end else begin
      n_tests++;
      if (q_i0[base] !== 64'hFF80_0000_0000_0000 || q_i1[base] !== 64'h007F_FF00_0000_0000) begin
        n_fail++;
        $display("FAIL neg_format: got %h/%h, expected ff80000000000000/007fff0000000000", q_i0[base], q_i1[base]);
      end
    end
    check_frames("neg", base, 1);
  endtask

  task automatic test_gaps;
    int base;
    int st;
    base = q_i0.size();
    for (int i = 0; i < 16; i++) stim[i] = 16'hF000 + 16'(i) * 16'h0123;
    send(16, 1'b1, st);
    wait_pairs(base + 8);
    check_frames("gaps", base, 1);
  endtask

  task automatic test_back_to_back;
    int base;
    int st;
    int nf;
    int spacing;
`ifdef FFT_BUF_PINGPONG_EN
    nf = 3;
    spacing = 16;
`else
    nf = 2;
    spacing = 24;
`endif
    base = q_i0.size();
    for (int i = 0; i < 64; i++) stim[i] = 16'(200 + i * 7);
    send(16 * nf, 1'b0, st);
    n_tests++;
`ifdef FFT_BUF_PINGPONG_EN
    if (st != 0) begin
      n_fail++;
      $display("FAIL b2b_stalls: got %0d stall cycles, expected 0", st);
    end
`else
    if (st != 8) begin
      n_fail++;
      $display("FAIL b2b_stalls: got %0d stall cycles, expected 8", st);
    end
`endif
    wait_pairs(base + 8 * nf);
    check_frames("b2b", base, nf);
    if (q_i0.size() - base == 8 * nf) begin
      for (int f = 1; f < nf; f++) begin
        n_tests++;
        if (q_cyc[base + 8*f] - q_cyc[base + 8*(f-1)] != spacing) begin
          n_fail++;
          $display("FAIL b2b_spacing f%0d: got %0d cycles, expected %0d", f,
                   q_cyc[base + 8*f] - q_cyc[base + 8*(f-1)], spacing);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    int base;
    int st;
    int g = 0;
    for (int i = 0; i < 16; i++) stim[i] = 16'(50 + i);
    send(16, 1'b0, st);
    while (!(pair_valid && pair_idx == 3'd3) && g < 40) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (!(pair_valid && pair_idx == 3'd3)) begin
      n_fail++;
      $display("FAIL rstmid_reach: got pv %b idx %0d, expected 1 3", pair_valid, pair_idx);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (pair_valid !== 1'b0 || pair_idx !== 3'd0 || pair_last !== 1'b0 || din_ready !== 1'b0 ||
        i0 !== 64'd0 || i1 !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got pv %b idx %0d pl %b rdy %b i0 %h i1 %h, expected all 0",
               pair_valid, pair_idx, pair_last, din_ready, i0, i1);
    end
    base = q_i0.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (q_i0.size() != base) begin
      n_fail++;
      $display("FAIL rstmid_stale: got %0d pairs, expected 0", q_i0.size() - base);
    end
    for (int i = 0; i < 16; i++) stim[i] = 16'(100 + i);
    send(16, 1'b0, st);
    wait_pairs(base + 8);
    n_tests++;
    if (q_i0.size() <= base) begin
      n_fail++;
      $display("FAIL rstmid_fresh_present: got %0d pairs, expected 8", q_i0.size() - base);
    end else begin
      n_tests++;
      if (q_idx[base] !== 3'd0 || q_i0[base] !== 64'h0000_6400_0000_0000 || q_i1[base] !== 64'h0000_6C00_0000_0000) begin
        n_fail++;
        $display("FAIL rstmid_first_pair: got idx %0d %h/%h, expected 0 0000640000000000/00006c0000000000",
                 q_idx[base], q_i0[base], q_i1[base]);
      end
    end
    check_frames("rstmid", base, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
